johnson_seq_ctrl: RTL and testbench
===================================

# johnson_seq_ctrl

Run controller for the 4-bit, 8-state Johnson counter used in the Lab1 display path. It owns the Johnson count register and advances it only when commanded: a fixed number of steps or continuously, forward or reverse. It reports busy/done/advance status to the upstream control logic. It sits between the switch/key conditioning logic and the LED/HEX output stage.

## Interface
- DIV, 4, prescale divisor; advance period in clocks when prescaling is compiled in; legal range 2..255
- STEPW, 8, width of the step-count input
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  single-cycle request to begin a run; honoured only in IDLE
- stop  in  1  abort request; honoured in RUN, and blocks start in IDLE
- dir  in  1  0 = forward, 1 = reverse; sampled on accepted start
- continuous  in  1  1 = run until stop; sampled on accepted start
- steps  in  STEPW  number of advances for a counted run; sampled on accepted start
- clr  in  1  synchronous clear of count to 0000; honoured only in IDLE
- count  out  4  Johnson code
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse on counted-run completion
- adv  out  1  one-cycle pulse coincident with each count change

## Operation
- Forward sequence: 0000→1000→1100→1110→1111→0111→0011→0001→0000. Reverse is the exact inverse. Wrap-around is seamless in both directions.
- Reset values: FSM=IDLE, count=0000, busy=0, done=0, adv=0, remaining=0, prescaler=0.
- FSM states:
  - IDLE
    - start & !stop → RUN; latch dir, continuous, steps into remaining.
    - Special case: start with continuous=0 and steps=0 → FINISH directly, with no advance.
    - clr & !start → count=0000.
  - RUN
    - On each advance tick, count steps one position in the latched direction, adv=1, and remaining decrements unless continuous.
    - Tick with remaining==1 (counted run) → FINISH.
    - stop → IDLE. No advance that cycle, even if a tick coincides. No done pulse. count holds.
  - FINISH: done=1 for exactly one cycle, busy=0, then IDLE.
- Ignored inputs:
  - start while in RUN or FINISH is ignored.
  - clr outside IDLE is ignored.
  - dir, continuous and steps are ignored outside the accepting cycle.
- Count is not cleared on start; each run continues from the current code.
- Illegal codes (e.g. 0100) are unreachable. This is guaranteed by construction, not checked.
- remaining is STEPW bits and decrements without wrap. Maximum counted run is 2^STEPW−1 advances.

## Timing
- Accepted start at edge k → busy=1 after edge k.
- Without prescale:
  - First count change occurs at edge k+1, and every cycle thereafter.
  - A counted run of N steps has its last advance at edge k+N.
  - FINISH (done=1) is visible after edge k+N, and IDLE after edge k+N+1.
- With prescale:
  - The prescaler zeroes on RUN entry and ticks when it equals DIV−1.
  - First change occurs at edge k+DIV, and every DIV edges thereafter.
  - The last advance of an N-step run is at edge k+N·DIV.
- adv, count and done are registered outputs, with no combinational path from inputs.
- stop asserted in the cycle before edge j → IDLE after edge j, busy=0 after edge j.
- Asynchronous reset takes effect immediately, mid-run included, and all outputs return to reset values. Release is synchronised externally.

## Configuration
- JC_PRESCALE_EN
  - Defined: the advance tick comes from the DIV-cycle prescaler, sized to hold DIV−1.
  - Undefined: the prescaler logic is absent, the tick is constant 1 in RUN, and DIV is unused.

## Test plan
- Reset mid-run: counted run in progress with count=1110; assert reset low between edges → count=0000, busy=0, done=0 immediately; IDLE after release.
- Counted forward, no prescale: from 0000, start with steps=3, dir=0 → count 1000, 1100, 1110 on edges k+1..k+3, adv each edge; done pulse after k+3; busy low after k+3.
- Reverse wrap: from 0000, start with steps=9, dir=1 → sequence 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001; done once.
- Continuous + stop collision: continuous run; stop asserted on a tick cycle → no advance that cycle, IDLE next edge, done never pulses; start and stop together in IDLE → stays IDLE.
- Zero steps / busy start / clr: start with steps=0 → done after 1 cycle, count unchanged; start during RUN → ignored, remaining unaffected; clr in IDLE with count=0111 → 0000 next edge.
- Prescale (JC_PRESCALE_EN, DIV=4): start with steps=2 → changes at k+4 and k+8 only; adv high exactly 2 cycles; done after k+8.

Source files
------------

// File: rtl/johnson_seq_ctrl_if.sv
// Command/status bundle between the upstream run control and the Johnson sequence controller.
interface johnson_seq_ctrl_if #(
    parameter int unsigned STEPW = 8
) ();
    logic             start;
    logic             stop;
    logic             dir;
    logic             continuous;
    logic [STEPW-1:0] steps;
    logic             clr;
    logic [3:0]       count;
    logic             busy;
    logic             done;
    logic             adv;

    modport master (
        output start, stop, dir, continuous, steps, clr,
        input  count, busy, done, adv
    );

    modport slave (
        input  start, stop, dir, continuous, steps, clr,
        output count, busy, done, adv
    );
endinterface

// File: rtl/johnson_seq_ctrl.sv
// Run controller owning the 4-bit Johnson count: counted or continuous runs, forward or reverse.
// Define JC_PRESCALE_EN to derive the advance tick from a DIV-cycle prescaler.
module johnson_seq_ctrl #(
    parameter int unsigned DIV   = 4,
    parameter int unsigned STEPW = 8
) (
    input logic               clk,
    input logic               reset,
    johnson_seq_ctrl_if.slave ctl
);

    if (DIV < 2 || DIV > 255) begin : gen_div_check
        $error("johnson_seq_ctrl: DIV must lie in 2..255");
    end
    if (STEPW < 1) begin : gen_stepw_check
        $error("johnson_seq_ctrl: STEPW must be at least 1");
    end

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFinish
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       count_q, count_d;
    logic             dir_q, dir_d;
    logic             cont_q, cont_d;
    logic [STEPW-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             adv_q, adv_d;
    logic             tick;

    // Forward shifts right feeding ~lsb into msb; reverse is the exact inverse.
    function automatic logic [3:0] jc_next(input logic [3:0] c, input logic rev);
        return rev ? {c[2:0], ~c[3]} : {~c[0], c[3:1]};
    endfunction

`ifdef JC_PRESCALE_EN
    localparam int unsigned PsW = $clog2(DIV);
    localparam logic [PsW-1:0] PsLast = PsW'(DIV - 1);

    logic [PsW-1:0] ps_q, ps_d;

    assign tick = (ps_q == PsLast);

    // Held at zero outside RUN, so every run starts a fresh DIV-cycle period.
    always_comb begin
        ps_d = '0;
        if (state_q == StRun && !tick) begin
            ps_d = ps_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        dir_d   = dir_q;
        cont_d  = cont_q;
        rem_d   = rem_q;
        adv_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (ctl.start && !ctl.stop) begin
                    dir_d  = ctl.dir;
                    cont_d = ctl.continuous;
                    rem_d  = ctl.steps;
                    if (!ctl.continuous && ctl.steps == '0) begin
                        state_d = StFinish;
                    end else begin
                        state_d = StRun;
                    end
                end else if (ctl.clr && !ctl.start) begin
                    count_d = 4'b0000;
                end
            end
            StRun: begin
                // stop wins over a coinciding tick: no advance, no done.
                if (ctl.stop) begin
                    state_d = StIdle;
                end else if (tick) begin
                    count_d = jc_next(count_q, dir_q);
                    adv_d   = 1'b1;
                    if (!cont_q) begin
                        if (rem_q != '0) begin
                            rem_d = rem_q - 1'b1;
                        end
                        if (rem_q == STEPW'(1)) begin
                            state_d = StFinish;
                        end
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StRun);
        done_d = (state_d == StFinish);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            count_q <= 4'b0000;
            dir_q   <= 1'b0;
            cont_q  <= 1'b0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            adv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            cont_q  <= cont_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            adv_q   <= adv_d;
        end
    end

    assign ctl.count = count_q;
    assign ctl.busy  = busy_q;
    assign ctl.done  = done_q;
    assign ctl.adv   = adv_q;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Scoreboard bench for johnson_seq_ctrl: stimulus queues expected adv/done events, a monitor
// pops and compares them whenever the DUT pulses adv or done.
module tb_johnson_seq_ctrl;
    localparam int unsigned TbDiv   = 4;
    localparam int unsigned TbStepw = 8;
`ifdef JC_PRESCALE_EN
    localparam int unsigned P = TbDiv;
`else
    localparam int unsigned P = 1;
`endif

    typedef struct {
        bit          is_done;
        logic [3:0]  cnt;
        int unsigned cyc;
    } exp_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    int unsigned cyc   = 0;
    int          n_pass  = 0;
    int          n_total = 0;
    exp_t        sb[$];
    logic [3:0]  seq[$];
    int unsigned k;

    johnson_seq_ctrl_if #(.STEPW(TbStepw)) bus ();

    johnson_seq_ctrl #(
        .DIV  (TbDiv),
        .STEPW(TbStepw)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .ctl  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_exp(input bit is_done, input logic [3:0] cnt, input int unsigned at);
        exp_t e;
        e.is_done = is_done;
        e.cnt     = cnt;
        e.cyc     = at;
        sb.push_back(e);
    endtask

    // Queue one adv per entry of seq, P cycles apart from start edge k, plus an optional done.
    task automatic push_run(input int unsigned kk, input int n, input bit with_done);
        for (int i = 0; i < n; i++) push_exp(1'b0, seq[i], kk + (i + 1) * P);
        if (with_done) push_exp(1'b1, seq[n-1], kk + n * P);
    endtask

    task automatic mon_event(input bit is_done, input logic [3:0] cnt);
        exp_t e;
        if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_%s: got pulse with count %b expected none (cycle %0d)",
                     is_done ? "done" : "adv", cnt, cyc);
            return;
        end
        e = sb.pop_front();
        check(is_done ? "event_kind_done" : "event_kind_adv", 32'(is_done), 32'(e.is_done));
        check("event_cycle", cyc, e.cyc);
        check("event_count", 32'(cnt), 32'(e.cnt));
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (bus.adv) mon_event(1'b0, bus.count);
            if (bus.done) mon_event(1'b1, bus.count);
        end
    end

    task automatic wait_cyc(input int unsigned target);
        while (cyc < target) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge (cyc == k).
    task automatic do_start(input bit d, input bit c, input logic [TbStepw-1:0] n);
        bus.start      = 1'b1;
        bus.dir        = d;
        bus.continuous = c;
        bus.steps      = n;
        @(negedge clk);
        bus.start      = 1'b0;
        bus.dir        = ~d;
        bus.continuous = ~c;
        bus.steps      = '1;
    endtask

    initial begin
        #(200000);
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start = 1'b0; bus.stop = 1'b0; bus.dir = 1'b0;
        bus.continuous = 1'b0; bus.steps = '0; bus.clr = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("reset_count", 32'(bus.count), 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);
        check("reset_done", 32'(bus.done), 32'h0);
        check("reset_adv", 32'(bus.adv), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Counted forward, 3 steps from 0000.
        seq = '{4'b1000, 4'b1100, 4'b1110};
        k = cyc + 1;
        push_run(k, 3, 1'b1);
        do_start(1'b0, 1'b0, 8'd3);
        check("fwd3_busy_after_start", 32'(bus.busy), 32'h1);
        wait_cyc(k + 3 * P);
        check("fwd3_busy_in_finish", 32'(bus.busy), 32'h0);
        @(negedge clk);
        check("fwd3_done_one_cycle", 32'(bus.done), 32'h0);

        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        check("clr_1110", 32'(bus.count), 32'h0);

        // Reverse 9 steps from 0000 wraps past 0000 to 0001.
        seq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001};
        k = cyc + 1;
        push_run(k, 9, 1'b1);
        do_start(1'b1, 1'b0, 8'd9);
        wait_cyc(k + 9 * P);
        @(negedge clk);
        check("rev9_final_count", 32'(bus.count), 32'b0001);

        // Forward 4 from 0001 with a conflicting start mid-run that must be ignored.
        seq = '{4'b0000, 4'b1000, 4'b1100, 4'b1110};
        k = cyc + 1;
        push_run(k, 4, 1'b1);
        do_start(1'b0, 1'b0, 8'd4);
        do_start(1'b1, 1'b1, 8'd1);
        wait_cyc(k + 4 * P);
        check("busy_start_ignored_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);

        // Zero steps: done on the accepting edge, no advance.
        k = cyc + 1;
        push_exp(1'b1, 4'b1110, k);
        do_start(1'b0, 1'b0, 8'd0);
        check("zero_steps_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        check("zero_steps_count", 32'(bus.count), 32'b1110);

        // Continuous reverse, stop lands on a tick cycle.
        seq = '{4'b1100, 4'b1000};
        k = cyc + 1;
        push_run(k, 2, 1'b0);
        do_start(1'b1, 1'b1, 8'd5);
        wait_cyc(k + 3 * P - 1);
        check("cont_busy_before_stop", 32'(bus.busy), 32'h1);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        check("stop_busy", 32'(bus.busy), 32'h0);
        check("stop_count_holds", 32'(bus.count), 32'b1000);
        repeat (2 * P + 2) @(negedge clk);

        // start together with stop in IDLE is refused.
        bus.stop = 1'b1;
        do_start(1'b0, 1'b0, 8'd3);
        bus.stop = 1'b0;
        check("start_stop_idle_busy", 32'(bus.busy), 32'h0);
        repeat (3 * P + 2) @(negedge clk);
        check("start_stop_idle_count", 32'(bus.count), 32'b1000);

        // Walk to 0111, then clear.
        seq = '{4'b1100, 4'b1110, 4'b1111, 4'b0111};
        k = cyc + 1;
        push_run(k, 4, 1'b1);
        do_start(1'b0, 1'b0, 8'd4);
        wait_cyc(k + 4 * P);
        @(negedge clk);
        check("pre_clr_count", 32'(bus.count), 32'b0111);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        check("clr_0111", 32'(bus.count), 32'h0);

        // Reset mid-run at count 1110.
        seq = '{4'b1000, 4'b1100, 4'b1110};
        k = cyc + 1;
        push_run(k, 3, 1'b0);
        do_start(1'b0, 1'b0, 8'd10);
        wait_cyc(k + 3 * P);
        #2 reset = 1'b0;
        #1;
        check("midrun_reset_count", 32'(bus.count), 32'h0);
        check("midrun_reset_busy", 32'(bus.busy), 32'h0);
        check("midrun_reset_done", 32'(bus.done), 32'h0);
        check("midrun_reset_adv", 32'(bus.adv), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2 * P + 2) @(negedge clk);
        check("post_reset_busy", 32'(bus.busy), 32'h0);
        check("post_reset_count", 32'(bus.count), 32'h0);

        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
